// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset synchroniser/sequencer.
// Latency: n/a. Backpressure: n/a.
// Holds the sequencer state encoding and the counter width rule.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        RESET   = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } rst_seq_state_e;

    // Counter must reach max(hold, step)-1 without wrapping.
    function automatic int cnt_w(input int hold, input int step);
        return $clog2(((hold > step) ? hold : step) + 1);
    endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// Async-assert, sync-deassert reset synchroniser chain.
// Latency: release seen STAGES edges after i_rst rises; assertion is immediate.
// Backpressure: none.
module rst_sync_chain #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_rst_s
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], 1'b1};
        end
    end

    assign o_rst_s = sync_q[STAGES-1];

endmodule

// File: rtl/rst_seq_sync.sv
// Reset synchroniser plus hold and staggered per-channel release sequencer.
// Latency: channel k released SYNC_STAGES+1+HOLD_CYCLES+k*STEP_CYCLES edges after i_rst rises.
// Backpressure: none; i_sw_rst restarts the sequence from RESET.
module rst_seq_sync
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int STEP_CYCLES = 3,
    parameter int NUM_CH      = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_sw_rst,
    output logic [NUM_CH-1:0] o_rst_n,
    output logic              o_rst_done,
    output logic              o_busy
);

    localparam int CW  = cnt_w(HOLD_CYCLES, STEP_CYCLES);
    localparam int CHW = $clog2(NUM_CH + 1);

    localparam logic [NUM_CH-1:0] CH0       = NUM_CH'(1);
    localparam logic [CW-1:0]     HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]     STEP_LAST = CW'(STEP_CYCLES - 1);
    localparam logic [CHW-1:0]    CH_LAST   = CHW'(NUM_CH - 1);

    logic           rst_s;
    rst_seq_state_e state;
    logic [CW-1:0]  cnt;
    logic [CHW-1:0] ch;

    rst_sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .o_rst_s (rst_s)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= RESET;
            cnt        <= '0;
            ch         <= '0;
            o_rst_n    <= '0;
            o_rst_done <= 1'b0;
            o_busy     <= 1'b0;
        end else if (i_sw_rst) begin
            state      <= RESET;
            cnt        <= '0;
            ch         <= '0;
            o_rst_n    <= '0;
            o_rst_done <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            case (state)
                RESET: begin
                    if (rst_s) begin
                        state  <= HOLD;
                        cnt    <= '0;
                        o_busy <= 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt     <= '0;
                        o_rst_n <= o_rst_n | CH0;
                        if (NUM_CH == 1) begin
                            state      <= RUN;
                            o_rst_done <= 1'b1;
                            o_busy     <= 1'b0;
                        end else begin
                            state <= RELEASE;
                            ch    <= CHW'(1);
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (cnt == STEP_LAST) begin
                        cnt     <= '0;
                        o_rst_n <= o_rst_n | (CH0 << ch);
                        if (ch == CH_LAST) begin
                            state      <= RUN;
                            o_rst_done <= 1'b1;
                            o_busy     <= 1'b0;
                        end else begin
                            ch <= ch + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                default: begin
                    state <= RESET;
                end
            endcase
        end
    end

endmodule

// File: doc/rst_seq_sync.md
Name: rst_seq_sync

Overview:
Parametrised reset synchroniser and sequencer for one clock domain.
- Synchronises the asynchronous active-low reset with a configurable flop chain.
- Stretches the synchronised release by a programmable hold time.
- Releases NUM_CH downstream reset outputs in a fixed staggered order.
- Accepts a synchronous software reset request that re-enters the full sequence.
- Instantiated once per clock domain at the top of each subsystem.

Parameters:
SYNC_STAGES, 2, synchroniser depth in flops; legal range >= 2.
HOLD_CYCLES, 4, cycles the reset is held after synchronised release; legal range >= 1.
STEP_CYCLES, 3, cycles between releases of consecutive channels; legal range >= 1.
NUM_CH, 3, number of sequenced reset outputs; legal range >= 1.

Ports:
i_clk       input   1       clock
i_rst       input   1       reset, asynchronous, active-low
i_sw_rst    input   1       software reset request, synchronous to i_clk, active-high, level
o_rst_n     output  NUM_CH  per-channel synchronised reset, active-low; bit 0 is released first
o_rst_done  output  1       all channels released; sequence complete
o_busy      output  1       sequence in progress (state HOLD or RELEASE)

Behaviour:
- i_rst low, asynchronously:
  - All sync flops clear.
  - o_rst_n = 0 (all bits), o_rst_done = 0, o_busy = 0.
  - FSM = RESET; counters = 0.
  - All outputs are registered flops with async clear. No combinational paths to outputs.
- Sync chain:
  - SYNC_STAGES flops; stage 0 input is constant 1.
  - rst_s = last stage output.
  - Assertion is asynchronous; deassertion is synchronous.
- FSM states: RESET, HOLD, RELEASE, RUN. Encoding comes from the package.
  - RESET: all o_rst_n = 0. If rst_s && !i_sw_rst, go to HOLD with cnt = 0.
  - HOLD: o_busy = 1 and cnt increments each cycle. When cnt == HOLD_CYCLES-1:
    - Set o_rst_n[0] = 1 and cnt = 0 on the same edge.
    - If NUM_CH == 1, go to RUN and set o_rst_done = 1 on that same edge.
    - Otherwise go to RELEASE with ch = 1.
  - RELEASE: o_busy = 1 and cnt increments. When cnt == STEP_CYCLES-1:
    - Set o_rst_n[ch] = 1 and cnt = 0.
    - If ch == NUM_CH-1, go to RUN and set o_rst_done = 1 on the same edge.
    - Otherwise ch increments.
  - RUN: o_rst_n all 1, o_rst_done = 1, o_busy = 0. Stays here until a reset source.
- Software reset:
  - i_sw_rst = 1 in any state causes, on the next edge: FSM = RESET, o_rst_n = 0, o_rst_done = 0, o_busy = 0, cnt = 0.
  - While i_sw_rst stays high, the FSM remains in RESET.
  - After i_sw_rst falls, the full HOLD and RELEASE sequence repeats. Minimum assertion is 1 + HOLD_CYCLES cycles.
- Released channels stay released (o_rst_n is thermometer-monotonic) until RESET is re-entered.
- Timing from i_rst deassertion (edge 1 = first edge that samples i_rst high):
  - rst_s = 1 after edge SYNC_STAGES.
  - HOLD is entered at edge SYNC_STAGES+1.
  - o_rst_n[k] rises at edge SYNC_STAGES+1+HOLD_CYCLES+k*STEP_CYCLES.
- i_rst reasserted mid-sequence: all outputs clear immediately (asynchronously); the sequence restarts from the sync chain.
- Counter widths:
  - cnt width = $clog2(max(HOLD_CYCLES, STEP_CYCLES)+1).
  - ch width = $clog2(NUM_CH+1).
  - No wrap-around is reachable.

Decomposition:
- Package rst_seq_pkg holds:
  - the state enum typedef rst_seq_state_e (RESET, HOLD, RELEASE, RUN);
  - a function cnt_w(hold, step) returning the counter width.
- Sub-module rst_sync_chain (parameter STAGES; ports i_clk, i_rst, o_rst_s): async-assert, sync-deassert flop chain. It is reused standalone elsewhere.

Test Plan:
- Defaults (SYNC_STAGES=2, HOLD_CYCLES=4, STEP_CYCLES=3, NUM_CH=3); deassert i_rst -> o_rst_n[0] rises at edge 7, [1] at edge 10, [2] at edge 13; o_rst_done=1 at edge 13; o_busy=1 on edges 3-12.
- In RUN, pulse i_sw_rst for 1 cycle -> next edge o_rst_n=000 and o_rst_done=0; o_rst_n[0] rises 1+4 edges after the pulse, then 3-cycle stagger.
- i_rst low asynchronously while in RELEASE with o_rst_n=001 -> o_rst_n=000 before the next clock edge; the sequence restarts with full timing after i_rst rises.
- Hold i_sw_rst high for 20 cycles after i_rst release -> o_rst_n stays 000 throughout; the sequence starts on the first edge after i_sw_rst falls.
- NUM_CH=1, HOLD_CYCLES=1, SYNC_STAGES=3 -> o_rst_n[0] and o_rst_done rise together at edge 5; RELEASE is never entered.
- Glitch check: a 1-cycle i_rst low pulse mid-RUN -> all outputs clear; recovery timing is identical to the cold-start case.
